// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller driving a single-port, word-wide BRAM
// with byte enables. Loads return right-aligned, zero-extended data.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   - misaligned WORD/DWORD accesses are flagged on fault and
//               suppressed at the BRAM; misaligned loads return 0.
//   undefined - fault is tied low and the offset is forced to alignment.
//
// Handshake: a request is taken in any cycle where busy=0 and
// dispatch_read or dispatch_write is high (write wins if both are high).
// While busy=1 dispatches are ignored, not queued. read_data is valid in the
// first busy=0 cycle after a load and holds until the next load completes.
module data_mem_ctrl #(
    parameter int ADDR_W       = 14,
    parameter int BRAM_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [31:0]       addr,
    input  logic [1:0]        mem_width,
    input  logic              dispatch_read,
    input  logic              dispatch_write,
    input  logic [31:0]       write_data,
    output logic              busy,
    output logic [31:0]       read_data,
    output logic              fault,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_WORD = 2'd1;

    // Last WAIT count value before moving to CAPTURE (WAIT lasts BRAM_LATENCY-1 cycles)
    localparam logic [1:0] WAIT_LAST = (BRAM_LATENCY >= 2) ? 2'(BRAM_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [1:0]  wait_cnt, wait_cnt_next;

    // Request attributes latched at acceptance
    logic [1:0]  off_q;
    logic [1:0]  width_q;
    logic        is_write_q;
    logic        misaligned_q;

    // Decode of the request currently presented by execute
    logic        accept;
    logic [1:0]  req_off;
    logic        req_misaligned;
    logic [3:0]  req_we;
    logic [31:0] req_din;
    logic [31:0] load_shifted;
    logic [31:0] load_value;

    // High address bits are deliberately ignored so addresses wrap
    logic        unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[31:ADDR_W+2]};

    assign accept    = (state == IDLE) && (dispatch_read || dispatch_write);
    assign dbg_state = state;

    // Request decode: offset, alignment, byte enables and lane-replicated data
    always_comb begin
        req_off        = addr[1:0];
        req_misaligned = 1'b0;
        req_we         = 4'hF;
        req_din        = write_data;
`ifdef DMEM_ALIGN_CHECK_EN
        if (mem_width == W_WORD)
            req_misaligned = addr[0];
        else if (mem_width != W_BYTE)
            req_misaligned = (addr[1:0] != 2'b00);
`else
        if (mem_width == W_WORD)
            req_off = addr[1:0] & 2'b10;
        else if (mem_width != W_BYTE)
            req_off = 2'b00;
`endif
        case (mem_width)
            W_BYTE: begin
                req_we  = 4'b0001 << req_off;
                req_din = {4{write_data[7:0]}};
            end
            W_WORD: begin
                req_we  = 4'b0011 << req_off;
                req_din = {2{write_data[15:0]}};
            end
            default: begin
                req_we  = 4'hF;
                req_din = write_data;
            end
        endcase
    end

    // Load result: right-align the addressed lane and zero-extend to width
    always_comb begin
        load_shifted = bram_dout >> {off_q, 3'b000};
        case (width_q)
            W_BYTE:  load_value = {24'd0, load_shifted[7:0]};
            W_WORD:  load_value = {16'd0, load_shifted[15:0]};
            default: load_value = load_shifted;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = ISSUE;
            end
            ISSUE: begin
                if (is_write_q) begin
                    state_next = IDLE;
                end else if (BRAM_LATENCY <= 1) begin
                    state_next = CAPTURE;
                end else begin
                    state_next    = WAIT;
                    wait_cnt_next = 2'd0;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST)
                    state_next = CAPTURE;
                else
                    wait_cnt_next = wait_cnt + 2'd1;
            end
            CAPTURE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Registered outputs and request latches; BRAM strobes last only for ISSUE
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy         <= 1'b0;
            read_data    <= 32'd0;
            fault        <= 1'b0;
            bram_en      <= 1'b0;
            bram_we      <= 4'd0;
            bram_addr    <= '0;
            bram_din     <= 32'd0;
            off_q        <= 2'd0;
            width_q      <= 2'd0;
            is_write_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            busy    <= (state_next != IDLE);
            bram_en <= 1'b0;
            bram_we <= 4'd0;
            fault   <= 1'b0;
            if (accept) begin
                off_q        <= req_off;
                width_q      <= mem_width;
                is_write_q   <= dispatch_write;
                misaligned_q <= req_misaligned;
                bram_addr    <= addr[ADDR_W+1:2];
                bram_din     <= req_din;
                bram_en      <= !req_misaligned;
                bram_we      <= (dispatch_write && !req_misaligned) ? req_we : 4'd0;
                fault        <= req_misaligned;
            end
            if (state == CAPTURE)
                read_data <= misaligned_q ? 32'd0 : load_value;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (default parameters).
// Includes a 2-cycle-latency BRAM model with read-first behaviour.
module tb_data_mem_ctrl;

    localparam int ADDR_W = 14;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic [31:0]       addr = '0;
    logic [1:0]        mem_width = '0;
    logic              dispatch_read = 1'b0;
    logic              dispatch_write = 1'b0;
    logic [31:0]       write_data = '0;
    logic              busy;
    logic [31:0]       read_data;
    logic              fault;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic [31:0]       bram_dout = '0;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    // Clock / reset block
    always #5 clk_in = ~clk_in;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .BRAM_LATENCY(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .addr(addr), .mem_width(mem_width),
        .dispatch_read(dispatch_read), .dispatch_write(dispatch_write),
        .write_data(write_data), .busy(busy), .read_data(read_data),
        .fault(fault), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
        .dbg_state(dbg_state)
    );

    // BRAM model: read latency 2, byte-enabled writes
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] rd_pipe = '0;
    always @(posedge clk_in) begin
        if (bram_en) begin
            rd_pipe <= mem[bram_addr];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
        end
        bram_dout <= rd_pipe;
    end

    // Activity monitors
    int en_cnt = 0;
    int capture_cnt = 0;
    always @(posedge clk_in) begin
        if (bram_en) en_cnt <= en_cnt + 1;
        if (dbg_state == 2'd3) capture_cnt <= capture_cnt + 1;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Driver: store, returns the ISSUE-cycle strobes and busy in T+1/T+2
    task automatic issue_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] wd,
                               output logic [3:0] we, output logic [31:0] din,
                               output logic [ADDR_W-1:0] ba, output logic b1, output logic b2);
        addr = a; mem_width = w; write_data = wd; dispatch_write = 1'b1;
        step();
        dispatch_write = 1'b0;
        we = bram_we; din = bram_din; ba = bram_addr; b1 = busy;
        step();
        b2 = busy;
    endtask

    // Driver: load, returns busy length, ISSUE observations and the result
    task automatic issue_load(input logic [31:0] a, input logic [1:0] w,
                              output int busy_cycles, output logic [31:0] rd,
                              output logic [ADDR_W-1:0] ba, output logic saw_en,
                              output logic saw_fault);
        addr = a; mem_width = w; dispatch_read = 1'b1;
        step();
        dispatch_read = 1'b0;
        busy_cycles = 0; saw_en = 1'b0; saw_fault = 1'b0; ba = bram_addr;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            busy_cycles++;
            saw_en = saw_en | bram_en;
            saw_fault = saw_fault | fault;
            step();
        end
        rd = read_data;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0 || read_data !== 32'd0 || bram_en !== 1'b0 || fault !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: busy=%b rd=%h en=%b fault=%b, want 0/0/0/0",
                         i, busy, read_data, bram_en, fault);
            end
            step();
        end
    endtask

    task automatic test_word();
        logic [3:0] we; logic [31:0] din, rd; logic [ADDR_W-1:0] ba;
        logic b1, b2, se, sf; int bc;
        issue_store(32'h10, 2'd2, 32'hDEADBEEF, we, din, ba, b1, b2);
        checks++;
        if (we !== 4'hF || din !== 32'hDEADBEEF || ba !== 14'd4) begin
            errors++;
            $display("FAIL sw_strobe: we=%h din=%h ba=%0d, want F DEADBEEF 4", we, din, ba);
        end
        checks++;
        if (b1 !== 1'b1 || b2 !== 1'b0) begin
            errors++;
            $display("FAIL sw_busy: T+1=%b T+2=%b, want 1 0", b1, b2);
        end
        issue_load(32'h10, 2'd2, bc, rd, ba, se, sf);
        checks++;
        if (bc !== 3 || rd !== 32'hDEADBEEF || ba !== 14'd4 || se !== 1'b1) begin
            errors++;
            $display("FAIL lw: busy=%0d rd=%h ba=%0d en=%b, want 3 DEADBEEF 4 1", bc, rd, ba, se);
        end
        issue_load(32'h10, 2'd1, bc, rd, ba, se, sf);
        checks++;
        if (rd !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL lhu_0x10: rd=%h, want 0000BEEF", rd);
        end
        issue_load(32'h11, 2'd0, bc, rd, ba, se, sf);
        checks++;
        if (rd !== 32'h000000BE) begin
            errors++;
            $display("FAIL lbu_0x11: rd=%h, want 000000BE", rd);
        end
    endtask

    task automatic test_subword();
        logic [3:0] we; logic [31:0] din, rd; logic [ADDR_W-1:0] ba;
        logic b1, b2, se, sf; int bc;
        issue_store(32'h13, 2'd0, 32'h000000AA, we, din, ba, b1, b2);
        checks++;
        if (we !== 4'b1000 || din !== 32'hAAAAAAAA || ba !== 14'd4) begin
            errors++;
            $display("FAIL sb_strobe: we=%b din=%h ba=%0d, want 1000 AAAAAAAA 4", we, din, ba);
        end
        issue_load(32'h13, 2'd0, bc, rd, ba, se, sf);
        checks++;
        if (rd !== 32'h000000AA) begin
            errors++;
            $display("FAIL lbu_0x13: rd=%h, want 000000AA", rd);
        end
        // word 4 is now AA_AD_BE_EF, so the upper half is AAAD
        issue_load(32'h12, 2'd1, bc, rd, ba, se, sf);
        checks++;
        if (rd !== 32'h0000AAAD) begin
            errors++;
            $display("FAIL lh_0x12: rd=%h, want 0000AAAD", rd);
        end
        issue_store(32'h16, 2'd1, 32'hCAFE1234, we, din, ba, b1, b2);
        checks++;
        if (we !== 4'b1100 || din !== 32'h12341234 || ba !== 14'd5) begin
            errors++;
            $display("FAIL sh_strobe: we=%b din=%h ba=%0d, want 1100 12341234 5", we, din, ba);
        end
        issue_load(32'h14, 2'd2, bc, rd, ba, se, sf);
        checks++;
        if (rd !== 32'h12340000) begin
            errors++;
            $display("FAIL lw_0x14: rd=%h, want 12340000", rd);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] we; logic [31:0] din, rd; logic [ADDR_W-1:0] ba;
        logic b1, b2, se, sf; int bc;
        issue_store(32'h0001_0020, 2'd2, 32'h0BADF00D, we, din, ba, b1, b2);
        checks++;
        if (ba !== 14'd8 || we !== 4'hF) begin
            errors++;
            $display("FAIL wrap_addr: ba=%0d we=%h, want 8 F", ba, we);
        end
        issue_load(32'h20, 2'd2, bc, rd, ba, se, sf);
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL wrap_read: rd=%h, want 0BADF00D", rd);
        end
    endtask

    task automatic test_busy_flood();
        int en0, cap0, hi;
        en0 = en_cnt; cap0 = capture_cnt; hi = 0;
        addr = 32'h10; mem_width = 2'd2; dispatch_read = 1'b1;
        step();
        addr = 32'h14;  // ignored requests point elsewhere
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            hi++;
            step();
        end
        dispatch_read = 1'b0;
        checks++;
        if (hi !== 3 || read_data !== 32'hAAADBEEF) begin
            errors++;
            $display("FAIL flood_result: busy=%0d rd=%h, want 3 AAADBEEF", hi, read_data);
        end
        step();
        step();
        checks++;
        if (en_cnt - en0 !== 1 || capture_cnt - cap0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flood_count: en=%0d cap=%0d busy=%b, want 1 1 0",
                     en_cnt - en0, capture_cnt - cap0, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [ADDR_W-1:0] ba; logic se, sf; int bc, cap0, en0;
        addr = 32'h14; mem_width = 2'd2; dispatch_read = 1'b1;
        step();
        dispatch_read = 1'b0;
        step();  // now in WAIT
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL rst_mid_pre: state=%0d, want 2", dbg_state);
        end
        rst_in = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || read_data !== 32'd0 || bram_en !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_async: busy=%b rd=%h en=%b st=%0d, want 0 0 0 0",
                     busy, read_data, bram_en, dbg_state);
        end
        step();
        rst_in = 1'b1;
        cap0 = capture_cnt; en0 = en_cnt;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (capture_cnt != cap0 || en_cnt != en0 || busy !== 1'b0 || read_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_after: cap=%0d en=%0d busy=%b rd=%h, want 0 0 0 0",
                     capture_cnt - cap0, en_cnt - en0, busy, read_data);
        end
        issue_load(32'h14, 2'd2, bc, rd, ba, se, sf);
        checks++;
        if (rd !== 32'h12340000 || bc !== 3) begin
            errors++;
            $display("FAIL rst_mid_reload: rd=%h busy=%0d, want 12340000 3", rd, bc);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] we; logic [31:0] din, rd; logic [ADDR_W-1:0] ba;
        logic b1, b2, se, sf; int bc;
        issue_load(32'h20, 2'd2, bc, rd, ba, se, sf);
        // store dispatched in the very cycle the load result appears
        issue_store(32'h24, 2'd2, 32'h00000055, we, din, ba, b1, b2);
        checks++;
        if (read_data !== 32'h0BADF00D || b1 !== 1'b1 || b2 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: rd=%h b1=%b b2=%b, want 0BADF00D 1 0", read_data, b1, b2);
        end
        issue_load(32'h24, 2'd2, bc, rd, ba, se, sf);
        checks++;
        if (rd !== 32'h00000055 || ba !== 14'd9) begin
            errors++;
            $display("FAIL b2b_load: rd=%h ba=%0d, want 00000055 9", rd, ba);
        end
    endtask

    task automatic test_align();
        logic [31:0] rd; logic [ADDR_W-1:0] ba; logic se, sf; int bc;
        issue_load(32'h22, 2'd2, bc, rd, ba, se, sf);
`ifdef DMEM_ALIGN_CHECK_EN
        checks++;
        if (sf !== 1'b1 || se !== 1'b0 || rd !== 32'd0 || bc !== 3) begin
            errors++;
            $display("FAIL align_chk: fault=%b en=%b rd=%h busy=%0d, want 1 0 0 3", sf, se, rd, bc);
        end
`else
        checks++;
        if (sf !== 1'b0 || se !== 1'b1 || ba !== 14'd8 || rd !== 32'h0BADF00D || bc !== 3) begin
            errors++;
            $display("FAIL align_force: fault=%b en=%b ba=%0d rd=%h busy=%0d, want 0 1 8 0BADF00D 3",
                     sf, se, ba, rd, bc);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'd0;
        rst_in = 1'b0;
        step();
        step();
        rst_in = 1'b1;
        test_reset();
        test_word();
        test_subword();
        test_wrap();
        test_busy_flood();
        test_reset_mid();
        test_back_to_back();
        test_align();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
